bird_kinematics: RTL and testbench

//  Parametrised velocity-based bird motion engine for the flappy game datapath.

---
 rtl/bird_kinematics.sv | 138 +++++++++++++
 tb/tb_bird_kinematics.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bird_kinematics.sv
// Velocity-based bird motion engine: gravity, flap impulse with cooldown,
// terminal velocity and ceiling/floor clamping, advanced once per frame tick.
module bird_kinematics #(
    parameter int W            = 11,
    parameter int VW           = 6,
    parameter int BIRD_X       = 150,
    parameter int START_Y      = 200,
    parameter int GRAVITY      = 1,
    parameter int FLAP_IMPULSE = 6,
    parameter int VMAX_DOWN    = 8,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 460,
    parameter int COOLDOWN     = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart,
    input  logic                 tick,
    input  logic                 enable,
    input  logic                 flap,
    input  logic                 collision,
    output logic [W-1:0]         bird_x,
    output logic [W-1:0]         bird_y,
    output logic signed [VW-1:0] velocity,
    output logic [1:0]           state,
    output logic                 dead
);

    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic signed [VW:0]  V_FLAP = (VW+1)'(-FLAP_IMPULSE);
    localparam logic signed [VW:0]  V_MAX  = (VW+1)'(VMAX_DOWN);
    localparam logic signed [VW:0]  V_GRAV = (VW+1)'(GRAVITY);
    localparam logic signed [W+1:0] Y_LO   = (W+2)'(Y_MIN);
    localparam logic signed [W+1:0] Y_HI   = (W+2)'(Y_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t                st_q, st_d;
    logic [W-1:0]          y_q, y_d;
    logic signed [VW-1:0]  v_q, v_d;
    logic [CW-1:0]         cd_q, cd_d;
    logic                  dead_q, dead_d;
    logic                  pend_q, pend_d;
    logic                  flap_q;
    logic                  flap_ok;
    logic signed [VW:0]    v_grav;
    logic signed [VW:0]    v_sel;
    logic signed [W+1:0]   y_ext;

    assign flap_ok = pend_q && (cd_q == '0);
    assign v_grav  = $signed({v_q[VW-1], v_q}) + V_GRAV;
    assign v_sel   = flap_ok ? V_FLAP
                   : ((v_grav > V_MAX) ? V_MAX : v_grav);
    // Candidate position in a wider signed space so it cannot wrap
    assign y_ext   = $signed({2'b00, y_q})
                   + $signed({{(W+1-VW){v_sel[VW]}}, v_sel});

    always_comb begin
        st_d   = st_q;
        y_d    = y_q;
        v_d    = v_q;
        cd_d   = cd_q;
        dead_d = dead_q;
        pend_d = pend_q | (flap & ~flap_q);
        if (tick) pend_d = 1'b0;
        unique case (st_q)
            IDLE: begin
                pend_d = 1'b0;
                y_d    = W'(START_Y);
                v_d    = '0;
                if (tick && enable) st_d = FLY;
            end
            FLY: begin
                if (tick) begin
                    if (collision) begin
                        st_d   = DEAD;
                        dead_d = 1'b1;
                    end else begin
                        if (flap_ok)
                            cd_d = CW'(COOLDOWN);
                        else if (cd_q != '0)
                            cd_d = cd_q - CW'(1);
                        if (y_ext < Y_LO) begin
                            y_d = W'(Y_MIN);
                            v_d = '0;
                        end else if (y_ext >= Y_HI) begin
                            y_d    = W'(Y_MAX);
                            v_d    = '0;
                            st_d   = DEAD;
                            dead_d = 1'b1;
                        end else begin
                            y_d = y_ext[W-1:0];
                            v_d = v_sel[VW-1:0];
                        end
                    end
                end
            end
            DEAD: begin
                pend_d = 1'b0;
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            st_q   <= IDLE;
            y_q    <= W'(START_Y);
            v_q    <= '0;
            cd_q   <= '0;
            dead_q <= 1'b0;
            pend_q <= 1'b0;
            flap_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            y_q    <= y_d;
            v_q    <= v_d;
            cd_q   <= cd_d;
            dead_q <= dead_d;
            pend_q <= pend_d;
            flap_q <= flap;
        end
    end

    assign bird_x   = W'(BIRD_X);
    assign bird_y   = y_q;
    assign velocity = v_q;
    assign state    = st_q;
    assign dead     = dead_q;

endmodule

// File: tb/tb_bird_kinematics.sv
// Bench for bird_kinematics: table of tick vectors plus hand sequences
// for floor, ceiling, collision, restart and mid-flight reset.
module tb_bird_kinematics;

    logic              clk = 1'b0;
    logic              reset, restart, tick, enable, flap, collision;
    logic [10:0]       bird_x, bird_y;
    logic signed [5:0] velocity;
    logic [1:0]        state;
    logic              dead;

    bird_kinematics dut (
        .clk(clk), .reset(reset), .restart(restart), .tick(tick),
        .enable(enable), .flap(flap), .collision(collision),
        .bird_x(bird_x), .bird_y(bird_y), .velocity(velocity),
        .state(state), .dead(dead)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit t; bit en; bit fl; bit col;
        int y; int v; int st;
    } vec_t;

    typedef struct {
        int y; int v; int st;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic push_exp(int ey, int ev, int est);
        exp_t e;
        e.y = ey; e.v = ev; e.st = est;
        sbq.push_back(e);
    endtask

    task automatic compare_out(string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, "_y"}, int'(bird_y), e.y);
        chk({tag, "_v"}, int'(velocity), e.v);
        chk({tag, "_state"}, int'(state), e.st);
        chk({tag, "_dead"}, int'(dead), (e.st == 2) ? 1 : 0);
    endtask

    task automatic apply(string tag, bit t, bit en, bit fl, bit col,
                         int ey, int ev, int est);
        if (fl) begin
            @(negedge clk);
            flap = 1'b1;
        end
        @(negedge clk);
        flap = 1'b0; tick = t; enable = en; collision = col;
        push_exp(ey, ev, est);
        @(negedge clk);
        tick = 1'b0; enable = 1'b0; collision = 1'b0;
        compare_out(tag);
    endtask

    initial begin
        int ey, vv;
        reset = 1'b1; restart = 1'b0; tick = 1'b0;
        enable = 1'b0; flap = 1'b0; collision = 1'b0;

        vecs.push_back('{1, 1, 0, 0, 200,  0, 1});
        vecs.push_back('{1, 0, 0, 0, 201,  1, 1});
        vecs.push_back('{1, 0, 0, 0, 203,  2, 1});
        vecs.push_back('{1, 0, 0, 0, 206,  3, 1});
        vecs.push_back('{0, 0, 0, 0, 206,  3, 1});
        vecs.push_back('{1, 0, 1, 0, 200, -6, 1});
        vecs.push_back('{1, 0, 1, 0, 195, -5, 1});
        vecs.push_back('{1, 0, 1, 0, 191, -4, 1});
        vecs.push_back('{1, 0, 1, 0, 188, -3, 1});
        vecs.push_back('{1, 0, 1, 0, 182, -6, 1});
        vecs.push_back('{1, 0, 0, 0, 177, -5, 1});
        vecs.push_back('{1, 0, 0, 0, 173, -4, 1});
        vecs.push_back('{1, 0, 0, 0, 170, -3, 1});
        vecs.push_back('{1, 0, 0, 0, 168, -2, 1});
        vecs.push_back('{1, 0, 0, 0, 167, -1, 1});
        vecs.push_back('{1, 0, 0, 0, 167,  0, 1});
        vecs.push_back('{1, 0, 0, 0, 168,  1, 1});
        vecs.push_back('{1, 0, 0, 0, 170,  2, 1});
        vecs.push_back('{1, 0, 0, 0, 173,  3, 1});
        vecs.push_back('{1, 0, 0, 0, 177,  4, 1});
        vecs.push_back('{1, 0, 0, 0, 182,  5, 1});
        vecs.push_back('{1, 0, 0, 0, 188,  6, 1});
        vecs.push_back('{1, 0, 0, 0, 195,  7, 1});
        vecs.push_back('{1, 0, 0, 0, 203,  8, 1});
        vecs.push_back('{1, 0, 0, 0, 211,  8, 1});

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_y", int'(bird_y), 200);
        chk("rst_v", int'(velocity), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_dead", int'(dead), 0);
        chk("bird_x", int'(bird_x), 150);

        for (int i = 0; i < vecs.size(); i++)
            apply($sformatf("vec%0d", i), vecs[i].t, vecs[i].en,
                  vecs[i].fl, vecs[i].col, vecs[i].y, vecs[i].v,
                  vecs[i].st);

        // Terminal-velocity fall into the floor
        ey = 211;
        while (ey + 8 < 460) begin
            ey += 8;
            apply("fall", 1, 0, 0, 0, ey, 8, 1);
        end
        apply("floor", 1, 0, 0, 0, 460, 0, 2);
        apply("dead_flap", 1, 1, 1, 0, 460, 0, 2);
        apply("dead_col", 1, 0, 0, 1, 460, 0, 2);

        @(negedge clk);
        restart = 1'b1;
        push_exp(200, 0, 0);
        @(negedge clk);
        restart = 1'b0;
        compare_out("restart");

        // Flap on every tick; only every fourth is accepted
        apply("start2", 1, 1, 0, 0, 200, 0, 1);
        ey = 200;
        for (int i = 0; i < 44; i++) begin
            vv = -6 + (i % 4);
            ey += vv;
            apply("climb", 1, 0, 1, 0, ey, vv, 1);
        end
        apply("ceiling", 1, 0, 1, 0, 0, 0, 1);
        apply("post_ceil1", 1, 0, 0, 0, 1, 1, 1);
        apply("post_ceil2", 1, 0, 0, 0, 3, 2, 1);
        apply("post_ceil3", 1, 0, 0, 0, 6, 3, 1);
        apply("col_flap", 1, 0, 1, 1, 6, 3, 2);

        @(negedge clk);
        restart = 1'b1;
        push_exp(200, 0, 0);
        @(negedge clk);
        restart = 1'b0;
        compare_out("restart2");

        apply("start3", 1, 1, 0, 0, 200, 0, 1);
        apply("fly3", 1, 0, 0, 0, 201, 1, 1);
        @(negedge clk);
        reset = 1'b1;
        push_exp(200, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        compare_out("mid_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
